// File: rtl/alu.sv
// alu: registered 32-bit execute-stage ALU with HI/LO product registers.
// One result per cycle; every output is a flop updated on the rising edge.
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input1,
  input  logic [31:0] input2,
  input  logic [6:0]  aluOp,
  output logic [31:0] ALUresult,
  output logic [31:0] hi_value,
  output logic [31:0] lo_value,
  output logic        zflag,
  output logic        signflag,
  output logic        carryflag,
  output logic        overflowflag
);

  localparam logic [6:0] OP_ADD   = 7'b0000000;
  localparam logic [6:0] OP_ADDI  = 7'b0000100;
  localparam logic [6:0] OP_MULTU = 7'b0000001;
  localparam logic [6:0] OP_MULT  = 7'b0000010;
  localparam logic [6:0] OP_COMP  = 7'b0000011;
  localparam logic [6:0] OP_AND   = 7'b0010000;
  localparam logic [6:0] OP_XOR   = 7'b0010001;
  localparam logic [6:0] OP_SHLL  = 7'b0100000;
  localparam logic [6:0] OP_SHRL  = 7'b0100001;
  localparam logic [6:0] OP_SHRA  = 7'b0100010;

  logic [32:0] sum_wide;
  logic [63:0] prod_u;
  logic [63:0] prod_s;
  logic [63:0] prod_sel;
  logic [4:0]  shamt;

  logic [31:0] res_next;
  logic        z_next;
  logic        s_next;
  logic        c_next;
  logic        v_next;
  logic        mul_wr;
  logic        res_flags;

  assign shamt = input2[4:0];

  // Datapath units: both multiplies use 64-bit operands so the low 64 bits
  // of the sign-extended product are the exact signed product.
  always_comb begin
    prod_u = {32'd0, input1} * {32'd0, input2};
    prod_s = {{32{input1[31]}}, input1} * {{32{input2[31]}}, input2};
  end

  // Opcode decode: result, flags and HI/LO write enable for this cycle.
  always_comb begin
    sum_wide  = 33'd0;
    prod_sel  = 64'd0;
    res_next  = 32'd0;
    z_next    = 1'b0;
    s_next    = 1'b0;
    c_next    = 1'b0;
    v_next    = 1'b0;
    mul_wr    = 1'b0;
    res_flags = 1'b0;
    case (aluOp)
      OP_ADD, OP_ADDI: begin
        sum_wide  = {1'b0, input1} + {1'b0, input2};
        res_next  = sum_wide[31:0];
        c_next    = sum_wide[32];
        v_next    = (input1[31] == input2[31]) && (sum_wide[31] != input1[31]);
        res_flags = 1'b1;
      end
      OP_COMP: begin
        // Negate as 0 + ~B + 1 so the carry-out is set only for B == 0.
        sum_wide  = {1'b0, ~input2} + 33'd1;
        res_next  = sum_wide[31:0];
        c_next    = sum_wide[32];
        v_next    = (input2 == 32'h8000_0000);
        res_flags = 1'b1;
      end
      OP_MULTU, OP_MULT: begin
        prod_sel = (aluOp == OP_MULT) ? prod_s : prod_u;
        res_next = prod_sel[31:0];
        z_next   = (prod_sel == 64'd0);
        s_next   = prod_sel[63];
        mul_wr   = 1'b1;
      end
      OP_AND: begin
        res_next  = input1 & input2;
        res_flags = 1'b1;
      end
      OP_XOR: begin
        res_next  = input1 ^ input2;
        res_flags = 1'b1;
      end
      OP_SHLL: begin
        res_next  = input1 << shamt;
        res_flags = 1'b1;
      end
      OP_SHRL: begin
        res_next  = input1 >> shamt;
        res_flags = 1'b1;
      end
      OP_SHRA: begin
        res_next  = $unsigned($signed(input1) >>> shamt);
        res_flags = 1'b1;
      end
      default: begin
        res_next = 32'd0;
      end
    endcase
    // Zero/sign follow the 32-bit result for every defined non-multiply op;
    // unknown opcodes leave all flags clear.
    if (res_flags) begin
      z_next = (res_next == 32'd0);
      s_next = res_next[31];
    end
  end

  // Result and flag registers: reloaded every edge, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ALUresult    <= 32'd0;
      zflag        <= 1'b0;
      signflag     <= 1'b0;
      carryflag    <= 1'b0;
      overflowflag <= 1'b0;
    end else begin
      ALUresult    <= res_next;
      zflag        <= z_next;
      signflag     <= s_next;
      carryflag    <= c_next;
      overflowflag <= v_next;
    end
  end

  // HI/LO registers: written only by multiplies; reset wins over a multiply.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_value <= 32'd0;
      lo_value <= 32'd0;
    end else if (mul_wr) begin
      hi_value <= prod_sel[63:32];
      lo_value <= prod_sel[31:0];
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed vectors with hand-computed expectations; the driver
// queues each expected response and a monitor checks it one edge later.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [31:0] input1;
  logic [31:0] input2;
  logic [6:0]  aluOp;
  logic [31:0] ALUresult;
  logic [31:0] hi_value;
  logic [31:0] lo_value;
  logic        zflag;
  logic        signflag;
  logic        carryflag;
  logic        overflowflag;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        z;
    logic        s;
    logic        c;
    logic        v;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  alu dut (
    .clk          (clk),
    .rst          (rst),
    .input1       (input1),
    .input2       (input2),
    .aluOp        (aluOp),
    .ALUresult    (ALUresult),
    .hi_value     (hi_value),
    .lo_value     (lo_value),
    .zflag        (zflag),
    .signflag     (signflag),
    .carryflag    (carryflag),
    .overflowflag (overflowflag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s actual=%08h required=%08h", nm, fld, act, req);
    end
  endtask

  task automatic chk1(input string nm, input string fld, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s actual=%0b required=%0b", nm, fld, act, req);
    end
  endtask

  // Drive one operation at the falling edge and queue what should appear
  // after the next rising edge.
  task automatic issue(input string nm, input logic r, input logic [6:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic [31:0] hi, input logic [31:0] lo,
                       input logic z, input logic s, input logic c, input logic v);
    exp_t e;
    @(negedge clk);
    rst    = r;
    aluOp  = op;
    input1 = a;
    input2 = b;
    e.name = nm; e.res = res; e.hi = hi; e.lo = lo;
    e.z = z; e.s = s; e.c = c; e.v = v;
    exp_q.push_back(e);
  endtask

  // Monitor: every result is visible 1 time unit after the edge that made it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk32(e.name, "ALUresult", ALUresult, e.res);
        chk32(e.name, "hi", hi_value, e.hi);
        chk32(e.name, "lo", lo_value, e.lo);
        chk1(e.name, "z", zflag, e.z);
        chk1(e.name, "sign", signflag, e.s);
        chk1(e.name, "carry", carryflag, e.c);
        chk1(e.name, "ovf", overflowflag, e.v);
      end
    end
  end

  localparam logic [6:0] ADD = 7'b0000000, ADDI = 7'b0000100, MULTU = 7'b0000001,
                         MULT = 7'b0000010, COMP = 7'b0000011, AND_ = 7'b0010000,
                         XOR_ = 7'b0010001, SHLL = 7'b0100000, SHRL = 7'b0100001,
                         SHRA = 7'b0100010;

  initial begin
    int guard;
    rst = 1'b1; aluOp = ADD; input1 = 32'd0; input2 = 32'd0;
    //     name            rst op     A             B             result        hi            lo            z  s  c  v
    issue("reset0",        1, ADD,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h0,        0, 0, 0, 0);
    issue("add_carry",     0, ADD,   32'hFFFFFFFF, 32'h80402000, 32'h80401FFF, 32'h0,        32'h0,        0, 1, 1, 0);
    issue("add_ovf",       0, ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0,        32'h0,        0, 1, 0, 1);
    issue("add_zero",      0, ADDI,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h0,        32'h0,        1, 0, 1, 0);
    issue("multu",         0, MULTU, 32'h40000000, 32'h40000000, 32'h00000000, 32'h10000000, 32'h00000000, 0, 0, 0, 0);
    issue("mult_neg",      0, MULT,  32'hBFFFFFFF, 32'h40000000, 32'hC0000000, 32'hEFFFFFFF, 32'hC0000000, 0, 1, 0, 0);
    issue("add_hold",      0, ADD,   32'h00000002, 32'h00000003, 32'h00000005, 32'hEFFFFFFF, 32'hC0000000, 0, 0, 0, 0);
    issue("comp",          0, COMP,  32'h12345678, 32'h80402000, 32'h7FBFE000, 32'hEFFFFFFF, 32'hC0000000, 0, 0, 0, 0);
    issue("comp_zero",     0, COMP,  32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'hEFFFFFFF, 32'hC0000000, 1, 0, 1, 0);
    issue("comp_min",      0, COMP,  32'h00000000, 32'h80000000, 32'h80000000, 32'hEFFFFFFF, 32'hC0000000, 0, 1, 0, 1);
    issue("and",           0, AND_,  32'h0003AA59, 32'h00015357, 32'h00010251, 32'hEFFFFFFF, 32'hC0000000, 0, 0, 0, 0);
    issue("xor",           0, XOR_,  32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0, 32'hEFFFFFFF, 32'hC0000000, 0, 0, 0, 0);
    issue("shll",          0, SHLL,  32'd32,       32'd5,        32'd1024,     32'hEFFFFFFF, 32'hC0000000, 0, 0, 0, 0);
    issue("shrl_mask",     0, SHRL,  32'd32,       32'h80000002, 32'd8,        32'hEFFFFFFF, 32'hC0000000, 0, 0, 0, 0);
    issue("shra",          0, SHRA,  32'h80000000, 32'd4,        32'hF8000000, 32'hEFFFFFFF, 32'hC0000000, 0, 1, 0, 0);
    issue("shll_amt0",     0, SHLL,  32'h92345678, 32'h00000020, 32'h92345678, 32'hEFFFFFFF, 32'hC0000000, 0, 1, 0, 0);
    issue("shra_31",       0, SHRA,  32'h80000001, 32'd31,       32'hFFFFFFFF, 32'hEFFFFFFF, 32'hC0000000, 0, 1, 0, 0);
    issue("shrl_31",       0, SHRL,  32'h80000000, 32'd31,       32'h00000001, 32'hEFFFFFFF, 32'hC0000000, 0, 0, 0, 0);
    issue("bad_op",        0, 7'h7F, 32'h00000000, 32'h00000000, 32'h00000000, 32'hEFFFFFFF, 32'hC0000000, 0, 0, 0, 0);
    issue("add_after_bad", 0, ADD,   32'h00000000, 32'h00000000, 32'h00000000, 32'hEFFFFFFF, 32'hC0000000, 1, 0, 0, 0);
    issue("multu_max",     0, MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 32'h00000001, 0, 1, 0, 0);
    issue("mult_m1",       0, MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000001, 0, 0, 0, 0);
    issue("mult_zero",     0, MULT,  32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 1, 0, 0, 0);
    issue("multu_pre",     0, MULTU, 32'h00010000, 32'h00030000, 32'h00000000, 32'h00000003, 32'h00000000, 0, 0, 0, 0);
    issue("rst_on_multu",  1, MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h0,        0, 0, 0, 0);
    issue("add_post_rst",  0, ADD,   32'd2,        32'd3,        32'd5,        32'h0,        32'h0,        0, 0, 0, 0);
    @(negedge clk);
    aluOp = 7'h7F;
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
